regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-read-port general-purpose register file for the MIPS datapath; next generation of the current 32x32 two-read file.
- Single posedge clock domain with synchronous reset. Adds:
  - configurable width, depth and read-port count;
  - a per-register busy scoreboard for long-latency producers such as loads;
  - a handshaked debug dump engine that streams every register out in index order.

Parameters:
- DATA_W, 32: register width in bits.
- DEPTH, 32: number of registers; must be a power of two, at least 4.
- NUM_RD, 2: number of independent read ports, 1..4.
- SP_INDEX, 29: index loaded with SP_RESET on reset.
- SP_RESET, 32'h7ffffffc: stack-pointer reset value, truncated to DATA_W.
- ZERO_REG, 1: when 1, register 0 always reads as zero and ignores writes.

Ports (AW = $clog2(DEPTH)):
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- rd_addr  in  NUM_RD*AW  read addresses; port k occupies bits [k*AW +: AW].
- rd_data  out  NUM_RD*DW  read data, same packing, DW = DATA_W.
- rd_busy  out  NUM_RD  scoreboard busy bit for each read port's address.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write address.
- wr_data  in  DATA_W  write data.
- sb_set_en  in  1  mark a register busy (producer issued).
- sb_set_addr  in  AW  register to mark busy.
- dbg_start  in  1  start a dump; a single-cycle pulse.
- dbg_valid  out  1  dump beat valid.
- dbg_ready  in  1  consumer accepts the beat.
- dbg_index  out  AW  index of the current beat.
- dbg_data  out  DATA_W  contents of register dbg_index.
- dbg_busy  out  1  dump in progress.

Behaviour:

Reset (reset==0 at posedge):
- All registers clear to 0, except SP_INDEX, which loads SP_RESET.
- All busy bits clear to 0.
- Dump FSM goes to IDLE.
- dbg_valid=0, dbg_busy=0, dbg_index=0.
- rd_data follows the reset array contents from the next cycle.
- Reset mid-dump aborts the dump with no further beats.

Read ports:
- Combinational from the array; zero-cycle latency.
- Ports are independent; any ports may share an address.

Write port:
- When wr_en=1, Registers[wr_addr] <= wr_data at posedge.
- The new value is visible on rd_data the following cycle.
- With ZERO_REG=1, writes to address 0 are dropped, and address 0 reads 0 and is never busy.

Scoreboard:
- sb_set_en sets busy[sb_set_addr].
- A write with wr_en clears busy[wr_addr].
- Same address, same cycle, set and write together: set wins. The write data still lands, and the register stays busy for the new producer.
- rd_busy[k] = busy[rd_addr[k]], combinational.

Dump FSM, states IDLE and STREAM:
- IDLE: on dbg_start, go to STREAM with dbg_index=0, dbg_valid=1, dbg_busy=1.
- STREAM:
  - dbg_data = live contents of Registers[dbg_index], reflecting writes already committed.
  - On dbg_valid && dbg_ready, dbg_index increments.
  - On an accepted beat at index DEPTH-1, return to IDLE with dbg_valid=0, dbg_busy=0, dbg_index=0.
  - dbg_valid holds and dbg_index is stable while dbg_ready=0.
  - dbg_start is ignored while in STREAM.
- The dump never blocks reads, writes or the scoreboard.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Each read port whose rd_addr equals wr_addr while wr_en=1 returns wr_data in the same cycle (write-through forwarding). rd_busy for that port reads 0 unless sb_set_en targets the same address.
  - Address 0 is still forced to 0 when ZERO_REG=1.
  - dbg_data is not bypassed.
- Undefined: same-cycle reads return the old array value, and rd_busy reflects the pre-write busy bit.

Decomposition:
- Package regfile_pkg:
  - localparam defaults: DATA_W, DEPTH, SP_INDEX, SP_RESET;
  - typedef for the dump state enum {DBG_IDLE, DBG_STREAM};
  - function clog2-based AW helper.
- One sub-module, regfile_dbg_dump: the dump FSM plus index counter. It outputs dbg_index and dbg_valid and takes dbg_data through from the array.

Test Plan:
- Reset with reset=0 for one cycle, then read all addresses -> r29=32'h7ffffffc, all others 0, all rd_busy=0.
- Write r5=32'hDEADBEEF, then read r5 on ports 0 and 1 the next cycle -> both 32'hDEADBEEF. Write r0=32'h1 -> r0 reads 0.
- sb_set r8, then write r8=32'h1234 -> busy from the cycle after the set, clear after the write. Simultaneous set r9 and write r9=32'h55 -> r9=32'h55 and busy=1.
- Bypass (REGFILE_BYPASS_EN): write r3=32'hA5A5 while rd_addr0=3 -> rd_data0=32'hA5A5 in the same cycle. Without the macro -> old value (0).
- Dump with dbg_ready toggled 1/0 each cycle -> 32 beats, index 0..31 in order, values match the array. No beat repeats or is skipped. dbg_busy drops after index 31. A dbg_start during the dump is ignored.
- Assert reset at dump index 10 -> dbg_valid=0 and dbg_busy=0 the next cycle. A new dbg_start restarts at index 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults, dump-state encoding and address-width helper for the
// multi-read-port register file.
package regfile_pkg;

    localparam int          DEF_DATA_W   = 32;
    localparam int          DEF_DEPTH    = 32;
    localparam int          DEF_SP_INDEX = 29;
    localparam logic [31:0] DEF_SP_RESET = 32'h7fff_fffc;

    typedef enum logic {
        DBG_IDLE,
        DBG_STREAM
    } dbg_state_t;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_dbg_dump.sv
// Debug dump engine: streams register indices 0..DEPTH-1 over a
// valid/ready handshake and passes the addressed register through as data.
module regfile_dbg_dump
    import regfile_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W,
    localparam int AW    = addr_w(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dbg_start,
    input  logic              dbg_ready,
    input  logic [DATA_W-1:0] reg_data,
    output logic              dbg_valid,
    output logic              dbg_busy,
    output logic [AW-1:0]     dbg_index,
    output logic [DATA_W-1:0] dbg_data
);

    localparam logic [AW-1:0] LAST_INDEX = AW'(DEPTH - 1);

    dbg_state_t state;

    assign dbg_data = reg_data;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= DBG_IDLE;
            dbg_valid <= 1'b0;
            dbg_busy  <= 1'b0;
            dbg_index <= '0;
        end else begin
            case (state)
                DBG_IDLE: begin
                    if (dbg_start) begin
                        state     <= DBG_STREAM;
                        dbg_valid <= 1'b1;
                        dbg_busy  <= 1'b1;
                        dbg_index <= '0;
                    end
                end
                DBG_STREAM: begin
                    if (dbg_valid && dbg_ready) begin
                        if (dbg_index == LAST_INDEX) begin
                            state     <= DBG_IDLE;
                            dbg_valid <= 1'b0;
                            dbg_busy  <= 1'b0;
                            dbg_index <= '0;
                        end else begin
                            dbg_index <= dbg_index + 1'b1;
                        end
                    end
                end
                default: state <= DBG_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read register file with busy scoreboard and debug dump.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int          DATA_W   = DEF_DATA_W,
    parameter int          DEPTH    = DEF_DEPTH,
    parameter int          NUM_RD   = 2,
    parameter int          SP_INDEX = DEF_SP_INDEX,
    parameter logic [31:0] SP_RESET = DEF_SP_RESET,
    parameter bit          ZERO_REG = 1'b1,
    localparam int         AW       = addr_w(DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     sb_set_en,
    input  logic [AW-1:0]            sb_set_addr,
    input  logic                     dbg_start,
    output logic                     dbg_valid,
    input  logic                     dbg_ready,
    output logic [AW-1:0]            dbg_index,
    output logic [DATA_W-1:0]        dbg_data,
    output logic                     dbg_busy
);

    localparam logic [DATA_W-1:0] SP_VAL = DATA_W'(SP_RESET);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              wr_ok;
    logic              set_ok;

    assign wr_ok  = wr_en     && !(ZERO_REG && (wr_addr == '0));
    assign set_ok = sb_set_en && !(ZERO_REG && (sb_set_addr == '0));

    always_ff @(posedge clock) begin
        if (!reset) begin
            // NOTE: the array is built from flops, not a RAM macro, so clearing every entry on reset is legal.
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= (i == SP_INDEX) ? SP_VAL : '0;
            end
            busy <= '0;
        end else begin
            if (wr_ok) begin
                regs[wr_addr] <= wr_data;
                busy[wr_addr] <= 1'b0;
            end
            // NOTE: non-blocking updates resolve last-writer-wins, so the set below overrides the clear above.
            if (set_ok) begin
                busy[sb_set_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: defaults first so no output bit is left unassigned on any path (no latch).
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_data[k*DATA_W +: DATA_W] = regs[rd_addr[k*AW +: AW]];
            rd_busy[k]                  = busy[rd_addr[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (rd_addr[k*AW +: AW] == wr_addr)) begin
                rd_data[k*DATA_W +: DATA_W] = wr_data;
                rd_busy[k]                  = sb_set_en && (sb_set_addr == wr_addr);
            end
`endif
            if (ZERO_REG && (rd_addr[k*AW +: AW] == '0)) begin
                rd_data[k*DATA_W +: DATA_W] = '0;
                rd_busy[k]                  = 1'b0;
            end
        end
    end

    regfile_dbg_dump #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_dbg_dump (
        .clock     (clock),
        .reset     (reset),
        .dbg_start (dbg_start),
        .dbg_ready (dbg_ready),
        .reg_data  (regs[dbg_index]),
        .dbg_valid (dbg_valid),
        .dbg_busy  (dbg_busy),
        .dbg_index (dbg_index),
        .dbg_data  (dbg_data)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: table-driven read/write/scoreboard vectors
// followed by hand-written dump and mid-dump reset sequences.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        sb_set_en;
    logic [4:0]  sb_set_addr;
    logic        dbg_start;
    logic        dbg_valid;
    logic        dbg_ready;
    logic [4:0]  dbg_index;
    logic [31:0] dbg_data;
    logic        dbg_busy;

    regfile_mp dut (
        .clock       (clock),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .dbg_start   (dbg_start),
        .dbg_valid   (dbg_valid),
        .dbg_ready   (dbg_ready),
        .dbg_index   (dbg_index),
        .dbg_data    (dbg_data),
        .dbg_busy    (dbg_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic        sb_set;
        logic [4:0]  sb_addr;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] exp0;
        logic [31:0] exp1;
        logic        eb0;
        logic        eb1;
    } vec_t;

    vec_t        vecs [16];
    logic [31:0] mem  [32];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int          exp_idx;
        int          budget;
        logic [31:0] d0, d1;

        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[29] = 32'h7fff_fffc;

        vecs[0]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd29, 5'd0,  32'h7fff_fffc, 32'h0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 5'd5,  32'hDEAD_BEEF, 1'b0, 5'd0,  5'd5,  5'd5,
                     BYP ? 32'hDEAD_BEEF : 32'h0, BYP ? 32'hDEAD_BEEF : 32'h0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd5,  5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 5'd0,  32'h1,         1'b0, 5'd0,  5'd0,  5'd29, 32'h0, 32'h7fff_fffc, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd0,  5'd5,  32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd8,  5'd8,  5'd0,  32'h0, 32'h0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 5'd8,  32'h1234,      1'b0, 5'd0,  5'd8,  5'd8,
                     BYP ? 32'h1234 : 32'h0, BYP ? 32'h1234 : 32'h0, !BYP, !BYP};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd8,  5'd8,  32'h1234, 32'h1234, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 5'd9,  32'h55,        1'b1, 5'd9,  5'd9,  5'd9,
                     BYP ? 32'h55 : 32'h0, BYP ? 32'h55 : 32'h0, BYP, BYP};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd9,  5'd8,  32'h55, 32'h1234, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 5'd3,  32'hA5A5,      1'b0, 5'd0,  5'd3,  5'd9,
                     BYP ? 32'hA5A5 : 32'h0, 32'h55, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd3,  5'd3,  32'hA5A5, 32'hA5A5, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  5'd0,  5'd3,  32'h0, 32'hA5A5, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd0,  5'd0,  32'h0, 32'h0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 5'd0,  5'd31, 5'd29,
                     BYP ? 32'hFFFF_FFFF : 32'h0, 32'h7fff_fffc, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd31, 5'd5,  32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b0, 1'b0};

        reset = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        sb_set_en = 1'b0; sb_set_addr = '0; dbg_start = 1'b0; dbg_ready = 1'b0;
        tick();
        reset = 1'b1;
        check("reset dbg_valid", 32'(dbg_valid), 32'h0);
        check("reset dbg_busy",  32'(dbg_busy),  32'h0);
        check("reset dbg_index", 32'(dbg_index), 32'h0);

        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(a), 5'(31 - a)};
            #1;
            check($sformatf("reset r%0d p0", 31 - a), rd_data[31:0],  mem[31 - a]);
            check($sformatf("reset r%0d p1", a),      rd_data[63:32], mem[a]);
            check($sformatf("reset busy a%0d", a),    32'(rd_busy),   32'h0);
        end
        tick();

        for (int v = 0; v < 16; v++) begin
            wr_en = vecs[v].wr_en; wr_addr = vecs[v].wr_addr; wr_data = vecs[v].wr_data;
            sb_set_en = vecs[v].sb_set; sb_set_addr = vecs[v].sb_addr;
            rd_addr = {vecs[v].ra1, vecs[v].ra0};
            #1;
            check($sformatf("vec%0d rd_data0", v), rd_data[31:0],      vecs[v].exp0);
            check($sformatf("vec%0d rd_data1", v), rd_data[63:32],     vecs[v].exp1);
            check($sformatf("vec%0d rd_busy0", v), 32'(rd_busy[0]),    32'(vecs[v].eb0));
            check($sformatf("vec%0d rd_busy1", v), 32'(rd_busy[1]),    32'(vecs[v].eb1));
            if (vecs[v].wr_en && vecs[v].wr_addr != 5'd0) mem[vecs[v].wr_addr] = vecs[v].wr_data;
            tick();
        end
        wr_en = 1'b0; sb_set_en = 1'b0;

        // Full dump with ready toggling and a stray start mid-stream.
        dbg_start = 1'b1;
        tick();
        dbg_start = 1'b0;
        exp_idx = 0;
        for (int cyc = 0; cyc < 200 && exp_idx < 32; cyc++) begin
            dbg_ready = (cyc % 2 == 0);
            dbg_start = (cyc == 5);
            #1;
            check($sformatf("dump c%0d valid", cyc), 32'(dbg_valid), 32'h1);
            check($sformatf("dump c%0d busy", cyc),  32'(dbg_busy),  32'h1);
            check($sformatf("dump c%0d index", cyc), 32'(dbg_index), 32'(exp_idx));
            check($sformatf("dump c%0d data", cyc),  dbg_data,       mem[exp_idx]);
            if (dbg_ready) exp_idx++;
            tick();
        end
        dbg_start = 1'b0; dbg_ready = 1'b0;
        check("dump beat count", 32'(exp_idx), 32'd32);
        check("dump end valid", 32'(dbg_valid), 32'h0);
        check("dump end busy",  32'(dbg_busy),  32'h0);
        check("dump end index", 32'(dbg_index), 32'h0);

        // Reset while the dump sits at index 10.
        dbg_start = 1'b1;
        tick();
        dbg_start = 1'b0;
        dbg_ready = 1'b1;
        budget = 0;
        while (dbg_index != 5'd10 && budget < 40) begin
            tick();
            budget++;
        end
        check("reach index 10", 32'(dbg_index), 32'd10);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort valid", 32'(dbg_valid), 32'h0);
        check("abort busy",  32'(dbg_busy),  32'h0);
        check("abort index", 32'(dbg_index), 32'h0);
        rd_addr = {5'd29, 5'd5};
        #1;
        d0 = rd_data[31:0];
        d1 = rd_data[63:32];
        check("post reset r5",  d0, 32'h0);
        check("post reset r29", d1, 32'h7fff_fffc);
        rd_addr = {5'd9, 5'd9};
        #1;
        check("post reset busy r9", 32'(rd_busy), 32'h0);
        tick();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[29] = 32'h7fff_fffc;

        dbg_ready = 1'b0;
        dbg_start = 1'b1;
        tick();
        dbg_start = 1'b0;
        check("restart valid", 32'(dbg_valid), 32'h1);
        check("restart index", 32'(dbg_index), 32'h0);
        check("restart data",  dbg_data,       mem[0]);
        dbg_ready = 1'b1;
        tick();
        dbg_ready = 1'b0;
        check("restart next index", 32'(dbg_index), 32'h1);
        check("restart next data",  dbg_data,       mem[1]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
